// File: rtl/alu_rr_scheduler_pkg.sv
// Shared ALU types: opcode width and encodings, and an ID-width helper.
// Imported by the scheduler, its arbiter, its interface and the ALU.
package alu_rr_scheduler_pkg;

  localparam int ALU_OP_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Requester-side bundle: request valid/ready/operands and response pulse.
// master = requesters, slave = scheduler.
interface alu_rr_scheduler_if
  import alu_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*DW-1:0]       req_a;
  logic [NREQ*DW-1:0]       req_b;
  logic [NREQ*ALU_OP_W-1:0] req_op;
  logic [NREQ-1:0]          rsp_valid;
  logic [DW-1:0]            rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first req at ptr, ptr+1, ... wins.
// Ports: req_i, ptr_i in; gnt_o (onehot), gnt_id_o, any_o out.
module alu_rr_scheduler_rr_arbiter
  import alu_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);
  // Scan from the far end back to ptr so the nearest request wins.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_i) + k) % NREQ;
      if (req_i[idx]) begin
        gnt_o    = NREQ'(1) << idx;
        gnt_id_o = IDW'(idx);
        any_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipelined_alu.sv
// Fixed-latency ALU: result_o = f(a_i, b_i, opcode_i) LAT cycles later.
// Ports: clk, a_i, b_i, opcode_i in; result_o out.
module pipelined_alu
  import alu_rr_scheduler_pkg::*;
#(
  parameter int DW  = 8,
  parameter int LAT = 2
) (
  input  logic                clk,
  input  logic [DW-1:0]       a_i,
  input  logic [DW-1:0]       b_i,
  input  logic [ALU_OP_W-1:0] opcode_i,
  output logic [DW-1:0]       result_o
);
  logic [DW-1:0] f;
  logic [DW-1:0] pipe_q [LAT];

  always_comb begin
    f = '0;
    unique case (opcode_i)
      OP_ADD: f = a_i + b_i;
      OP_SUB: f = a_i - b_i;
      OP_AND: f = a_i & b_i;
      OP_XOR: f = a_i ^ b_i;
      default: f = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= f;
    for (int s = 1; s < LAT; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign result_o = pipe_q[LAT-1];
endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one pipelined ALU among NREQ requesters with round-robin grants.
// Ports: clk, reset, pause_i, bus (slave), alu_*_o/alu_result_i, issue_cnt_o.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int ALU_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause_i,
  alu_rr_scheduler_if.slave   bus,
  output logic [DW-1:0]       alu_a_o,
  output logic [DW-1:0]       alu_b_o,
  output logic [ALU_OP_W-1:0] alu_opcode_o,
  input  logic [DW-1:0]       alu_result_i,
  output logic [15:0]         issue_cnt_o
);
  localparam int IDW = id_w(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [DW-1:0]       a_q, a_d;
  logic [DW-1:0]       b_q, b_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [15:0]         cnt_q, cnt_d;
  tag_t                tag_q [ALU_LAT+1];
  tag_t                tag_d;

  logic [NREQ-1:0] req_m;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            acc;

  assign req_m = bus.req_valid & {NREQ{~pause_i & ~reset}};

  alu_rr_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i    (req_m),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (acc)
  );

  always_comb begin
    ptr_d = ptr_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    tag_d = '0;
    if (acc) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      a_d   = bus.req_a[int'(gnt_id)*DW +: DW];
      b_d   = bus.req_b[int'(gnt_id)*DW +: DW];
      op_d  = bus.req_op[int'(gnt_id)*ALU_OP_W +: ALU_OP_W];
      cnt_d = cnt_q + 16'd1;
      tag_d = '{vld: 1'b1, id: gnt_id};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      for (int s = 0; s <= ALU_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      tag_q[0] <= tag_d;
      for (int s = 1; s <= ALU_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Last tag stage lines up with the ALU result of the same op.
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = tag_q[ALU_LAT].vld
                       ? NREQ'(1) << tag_q[ALU_LAT].id
                       : '0;
  assign bus.rsp_data  = alu_result_i;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_opcode_o  = op_q;
  assign issue_cnt_o   = cnt_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler with a real pipelined_alu behind it.
// Reference model: grant search, op queue with due cycles, plain arithmetic.
module tb_alu_rr_scheduler;
  import alu_rr_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [1:0]    alu_op;
  logic [15:0]   icnt;

  alu_rr_scheduler #(
    .NREQ(NREQ), .DW(DW), .ALU_LAT(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pause_i      (pause),
    .bus          (bus),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_opcode_o (alu_op),
    .alu_result_i (alu_res),
    .issue_cnt_o  (icnt)
  );

  pipelined_alu #(.DW(DW), .LAT(LAT)) u_alu (
    .clk      (clk),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .opcode_i (alu_op),
    .result_o (alu_res)
  );

  typedef struct {
    int         due;
    int         id;
    logic [7:0] res;
  } pend_t;

  pend_t      pq[$];
  int         nchk = 0;
  int         nerr = 0;
  int         cyc = 0;
  bit         known = 0;
  int         mptr = 0;
  int         mcnt = 0;
  logic [7:0] ma = 0, mb = 0;
  logic [1:0] mop = 0;
  int         last_gnt;
  logic [3:0] obs_rsp;
  logic [7:0] obs_data;

  function automatic logic [7:0] alu_ref(
    input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0: return 8'((int'(a) + int'(b)) % 256);
      2'd1: return 8'((int'(a) - int'(b) + 256) % 256);
      2'd2: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int model_grant();
    if (reset || pause) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_ops();
    bus.req_a  = $urandom;
    bus.req_b  = $urandom;
    bus.req_op = 8'($urandom);
  endtask

  task automatic cycle();
    int g;
    logic [3:0] eg, ev;
    logic [7:0] ed;
    bit have;
    @(negedge clk);
    g = model_grant();
    eg = (g < 0) ? 4'd0 : 4'(1 << g);
    nchk++;
    if (bus.req_ready !== eg) begin
      nerr++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, eg);
    end
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) last_gnt = i;
    obs_rsp  = bus.rsp_valid;
    obs_data = bus.rsp_data;
    if (known) begin
      ev = 0; ed = 0; have = 0;
      foreach (pq[i]) begin
        if (pq[i].due == cyc) begin
          ev = 4'(1 << pq[i].id); ed = pq[i].res; have = 1;
        end
      end
      nchk++;
      if (bus.rsp_valid !== ev) begin
        nerr++;
        $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, ev);
      end
      if (have) begin
        nchk++;
        if (bus.rsp_data !== ed) begin
          nerr++;
          $display("FAIL rsp_data cyc=%0d got=%0d exp=%0d", cyc, bus.rsp_data, ed);
        end
      end
      nchk++;
      if (alu_a !== ma || alu_b !== mb || alu_op !== mop) begin
        nerr++;
        $display("FAIL alu_in cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                 cyc, alu_a, alu_b, alu_op, ma, mb, mop);
      end
      nchk++;
      if (icnt !== 16'(mcnt)) begin
        nerr++;
        $display("FAIL issue_cnt cyc=%0d got=%0d exp=%0d", cyc, icnt, mcnt);
      end
    end
    while (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
    if (reset) begin
      mptr = 0; mcnt = 0; ma = 0; mb = 0; mop = 0;
      pq.delete();
      known = 1;
    end else if (g >= 0) begin
      ma  = bus.req_a[g*DW +: DW];
      mb  = bus.req_b[g*DW +: DW];
      mop = bus.req_op[g*2 +: 2];
      pq.push_back('{cyc + 1 + LAT, g, alu_ref(ma, mb, mop)});
      mptr = (g + 1) % NREQ;
      mcnt = (mcnt + 1) % 65536;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    repeat (LAT + 2) cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 4'hF;
    rand_ops();
    repeat (3) cycle();
    nchk++;
    if (bus.req_ready !== 4'd0 || bus.rsp_valid !== 4'd0 ||
        alu_a !== 8'd0 || alu_b !== 8'd0 || alu_op !== 2'd0 ||
        icnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_state got rdy=%b rsp=%b a=%0d b=%0d op=%0d cnt=%0d exp all 0",
               bus.req_ready, bus.rsp_valid, alu_a, alu_b, alu_op, icnt);
    end
    reset = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    int seen_at;
    logic [3:0] sv;
    logic [7:0] sd;
    seen_at = -1; sv = 0; sd = 0;
    rand_ops();
    bus.req_valid = 4'b0001;
    bus.req_a[7:0] = 8'd10;
    bus.req_b[7:0] = 8'd5;
    bus.req_op[1:0] = 2'b00;
    cycle();
    bus.req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (obs_rsp != 0 && seen_at < 0) begin
        seen_at = k; sv = obs_rsp; sd = obs_data;
      end
    end
    nchk++;
    if (seen_at != 1 + LAT || sv !== 4'b0001 || sd !== 8'd15) begin
      nerr++;
      $display("FAIL single_op got at=%0d v=%b d=%0d exp at=%0d v=0001 d=15",
               seen_at, sv, sd, 1 + LAT);
    end
    nchk++;
    if (icnt !== 16'd1) begin
      nerr++;
      $display("FAIL single_cnt got=%0d exp=1", icnt);
    end
  endtask

  task automatic test_fairness();
    int g_log[$];
    int r_log[$];
    do_reset();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) bus.req_valid = '0;
      rand_ops();
      cycle();
      if (last_gnt >= 0) g_log.push_back(last_gnt);
      for (int i = 0; i < NREQ; i++) if (obs_rsp[i]) r_log.push_back(i);
    end
    nchk++;
    if (g_log.size() != 8) begin
      nerr++;
      $display("FAIL fair_grants got=%0d exp=8", g_log.size());
    end else begin
      foreach (g_log[i]) begin
        nchk++;
        if (g_log[i] != i % 4) begin
          nerr++;
          $display("FAIL fair_order idx=%0d got=%0d exp=%0d", i, g_log[i], i % 4);
        end
      end
    end
    nchk++;
    if (r_log.size() != 8) begin
      nerr++;
      $display("FAIL fair_rsps got=%0d exp=8", r_log.size());
    end else begin
      foreach (r_log[i]) begin
        nchk++;
        if (r_log[i] != i % 4) begin
          nerr++;
          $display("FAIL fair_rsp_order idx=%0d got=%0d exp=%0d", i, r_log[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_skip();
    int g_log[$];
    int want[3];
    want = '{3, 1, 3};
    do_reset();
    bus.req_valid = 4'b0010;
    rand_ops();
    cycle();
    nchk++;
    if (last_gnt != 1) begin
      nerr++;
      $display("FAIL skip_setup got=%0d exp=1", last_gnt);
    end
    bus.req_valid = 4'b1010;
    repeat (3) begin
      rand_ops();
      cycle();
      g_log.push_back(last_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      nchk++;
      if (g_log[i] != want[i]) begin
        nerr++;
        $display("FAIL skip_order idx=%0d got=%0d exp=%0d", i, g_log[i], want[i]);
      end
    end
    drain();
  endtask

  task automatic test_pause();
    int rdy_cnt, rsp_cnt;
    int at[$];
    rdy_cnt = 0; rsp_cnt = 0;
    bus.req_valid = 4'hF;
    repeat (2) begin
      rand_ops();
      cycle();
    end
    pause = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      cycle();
      if (last_gnt >= 0) rdy_cnt++;
      if (obs_rsp != 0) begin
        rsp_cnt++;
        at.push_back(k);
      end
    end
    nchk++;
    if (rdy_cnt != 0) begin
      nerr++;
      $display("FAIL pause_ready got=%0d exp=0", rdy_cnt);
    end
    nchk++;
    if (rsp_cnt != 2 || at.size() != 2 || at[0] != 1 || at[1] != 2) begin
      nerr++;
      $display("FAIL pause_drain got=%0d pulses exp=2 at 1,2", rsp_cnt);
    end
    pause = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int rsp_cnt;
    rsp_cnt = 0;
    drain();
    rand_ops();
    bus.req_valid = 4'b0100;
    bus.req_a[16 +: 8] = 8'd20;
    bus.req_b[16 +: 8] = 8'd8;
    bus.req_op[4 +: 2] = 2'b00;
    cycle();
    nchk++;
    if (last_gnt != 2) begin
      nerr++;
      $display("FAIL mid_accept got=%0d exp=2", last_gnt);
    end
    bus.req_valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (5) begin
      cycle();
      if (obs_rsp != 0) rsp_cnt++;
    end
    nchk++;
    if (rsp_cnt != 0) begin
      nerr++;
      $display("FAIL mid_dropped got=%0d pulses exp=0", rsp_cnt);
    end
    bus.req_valid = 4'hF;
    cycle();
    nchk++;
    if (last_gnt != 0) begin
      nerr++;
      $display("FAIL mid_ptr got=%0d exp=0", last_gnt);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.req_valid = 4'($urandom);
      pause = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      rand_ops();
      cycle();
    end
    pause = 1'b0;
    reset = 1'b0;
    drain();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    test_reset();
    test_single();
    test_fairness();
    test_skip();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
